// File: rtl/button_bounce_gen.sv
// -----------------------------------------------------------------------------
// button_bounce_gen
//
// Emulates a mechanically noisy push button. On a start command it drives a
// configurable number of (~target, target) bounce pairs onto button_out, then
// holds the target level for a programmable settle time and signals done.
// The level then stays at target until the next command. Dwell time of each
// bounce phase is either one cycle or pseudo-random from a 16-bit LFSR.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   start          command strobe, only honoured while idle
//   target_level   final settled level for this command
//   bounce_edges   number of (~target, target) bounce pairs, 0 = none
//   stable_cycles  cycles to hold target after bouncing (0 behaves as 1)
//   button_out     registered emulated button level
//   busy           high from command acceptance until done
//   done           one-cycle completion pulse
// -----------------------------------------------------------------------------
module button_bounce_gen #(
  parameter int          EDGE_W     = 4,
  parameter int          STABLE_W   = 24,
  parameter int          DWELL_W    = 3,
  parameter int          RANDOM     = 0,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                target_level,
  input  logic [EDGE_W-1:0]   bounce_edges,
  input  logic [STABLE_W-1:0] stable_cycles,
  output logic                button_out,
  output logic                busy,
  output logic                done
);

  // One down-counter serves both the bounce dwell and the settle time, so it
  // must be wide enough for whichever of the two is larger.
  localparam int CNT_W = (STABLE_W > DWELL_W) ? STABLE_W : DWELL_W;

  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [EDGE_W-1:0]   EDGE_ONE = EDGE_W'(1);
  localparam logic [STABLE_W-1:0] STB_ONE  = STABLE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_OFF,
    S_BOUNCE_ON,
    S_STABLE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   pairs_q, pairs_d;
  logic [STABLE_W-1:0] hold_q, hold_d;
  logic                tgt_q, tgt_d;
  logic                out_d, busy_d, done_d;
  logic [15:0]         lfsr_q;
  logic [CNT_W-1:0]    dwell_ld;

  // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  // Counter preload for a bounce phase of D cycles is D-1. With RANDOM off
  // D is always 1 (preload 0); otherwise D-1 is the raw LFSR field, which
  // gives a dwell of 1..2^DWELL_W without any adder.
  function automatic logic [CNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] field);
    logic [CNT_W-1:0] d;
    d = '0;
    d[DWELL_W-1:0] = (RANDOM != 0) ? field : '0;
    return d;
  endfunction

  // Counter preload for the settle phase: max(S,1)-1, clamping S = 0 to a
  // single cycle instead of letting S-1 wrap to the full counter range.
  function automatic logic [CNT_W-1:0] stable_load(input logic [STABLE_W-1:0] s);
    logic [CNT_W-1:0] r;
    r = '0;
    if (s != '0) begin
      r[STABLE_W-1:0] = s - STB_ONE;
    end
    return r;
  endfunction

  // The dwell is sampled from the LFSR value present on the edge that enters
  // the bounce phase.
  assign dwell_ld = dwell_load(lfsr_q[DWELL_W-1:0]);

  // ---- next-state / next-output logic ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pairs_d = pairs_q;
    hold_d  = hold_q;
    tgt_d   = tgt_q;
    out_d   = button_out;
    busy_d  = busy;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          tgt_d  = target_level;
          hold_d = stable_cycles;
          busy_d = 1'b1;
          if (bounce_edges != '0) begin
            state_d = S_BOUNCE_OFF;
            pairs_d = bounce_edges;
            cnt_d   = dwell_ld;
            out_d   = ~target_level;
          end else begin
            state_d = S_STABLE;
            pairs_d = '0;
            cnt_d   = stable_load(stable_cycles);
            out_d   = target_level;
          end
        end
      end

      S_BOUNCE_OFF: begin
        if (cnt_q == '0) begin
          state_d = S_BOUNCE_ON;
          cnt_d   = dwell_ld;
          out_d   = tgt_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_BOUNCE_ON: begin
        if (cnt_q == '0) begin
          // Finishing a pair: more than one left means another OFF phase;
          // otherwise the level is already at target and settling starts.
          // Comparing against one keeps the pair counter from underflowing.
          if (pairs_q > EDGE_ONE) begin
            state_d = S_BOUNCE_OFF;
            pairs_d = pairs_q - EDGE_ONE;
            cnt_d   = dwell_ld;
            out_d   = ~tgt_q;
          end else begin
            state_d = S_STABLE;
            pairs_d = '0;
            cnt_d   = stable_load(hold_q);
            out_d   = tgt_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_STABLE: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_DONE: begin
        // start is deliberately not looked at here; the next command is
        // taken from IDLE, which yields a one-cycle gap between commands.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---- state and output registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pairs_q    <= '0;
      hold_q     <= '0;
      tgt_q      <= IDLE_LEVEL;
      lfsr_q     <= SEED;
      button_out <= IDLE_LEVEL;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pairs_q    <= pairs_d;
      hold_q     <= hold_d;
      tgt_q      <= tgt_d;
      lfsr_q     <= lfsr_next(lfsr_q);
      button_out <= out_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_button_bounce_gen.sv
module tb_button_bounce_gen;

  localparam int          EDGE_W    = 4;
  localparam int          STABLE_W  = 24;
  localparam int          DWELL_W   = 3;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          COUNT_MAX = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start0 = 1'b0;
  logic                start1 = 1'b0;
  logic                target_level = 1'b0;
  logic [EDGE_W-1:0]   bounce_edges = '0;
  logic [STABLE_W-1:0] stable_cycles = '0;
  logic                out0, busy0, done0;
  logic                out1, busy1, done1;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  button_bounce_gen #(
    .EDGE_W(EDGE_W), .STABLE_W(STABLE_W), .DWELL_W(DWELL_W),
    .RANDOM(0), .SEED(SEED), .IDLE_LEVEL(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start0), .target_level(target_level),
    .bounce_edges(bounce_edges), .stable_cycles(stable_cycles),
    .button_out(out0), .busy(busy0), .done(done0)
  );

  button_bounce_gen #(
    .EDGE_W(EDGE_W), .STABLE_W(STABLE_W), .DWELL_W(DWELL_W),
    .RANDOM(1), .SEED(SEED), .IDLE_LEVEL(1'b0)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .target_level(target_level),
    .bounce_edges(bounce_edges), .stable_cycles(stable_cycles),
    .button_out(out1), .busy(busy1), .done(done1)
  );

  // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, reset to SEED, one step per clock.
  function automatic logic [15:0] ref_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= ref_step(m_lfsr);
  end

  // Debouncer (COUNT_MAX consecutive differing samples) plus press counter on dut0.
  logic deb;
  int   dcnt;
  int   press_count;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= 1'b0; dcnt <= 0; press_count <= 0;
    end else if (out0 !== deb) begin
      if (dcnt == COUNT_MAX - 1) begin
        deb  <= out0;
        dcnt <= 0;
        if (out0) press_count <= press_count + 1;
      end else begin
        dcnt <= dcnt + 1;
      end
    end else begin
      dcnt <= 0;
    end
  end

  // Issue a one-cycle start on dut0; returns at the negedge after the start edge.
  task automatic issue0(input logic tgt, input int e, input int s);
    target_level  = tgt;
    bounce_edges  = e[EDGE_W-1:0];
    stable_cycles = s[STABLE_W-1:0];
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input int limit, output int n);
    n = 0;
    while (done0 !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (out0 !== 1'b0)  begin failed++; $display("FAIL rst_out0 got=%b exp=0", out0); end
    tests++; if (busy0 !== 1'b0) begin failed++; $display("FAIL rst_busy0 got=%b exp=0", busy0); end
    tests++; if (done0 !== 1'b0) begin failed++; $display("FAIL rst_done0 got=%b exp=0", done0); end
    tests++; if (out1 !== 1'b0)  begin failed++; $display("FAIL rst_out1 got=%b exp=0", out1); end
    tests++; if (busy1 !== 1'b0) begin failed++; $display("FAIL rst_busy1 got=%b exp=0", busy1); end
    tests++; if (done1 !== 1'b0) begin failed++; $display("FAIL rst_done1 got=%b exp=0", done1); end
    reset = 1'b1;
    @(negedge clk);
    issue0(1'b0, 3, 5);
    // Now in BOUNCE_OFF: level is ~target = 1.
    tests++; if (out0 !== 1'b1)  begin failed++; $display("FAIL midrst_pre_out got=%b exp=1", out0); end
    tests++; if (busy0 !== 1'b1) begin failed++; $display("FAIL midrst_pre_busy got=%b exp=1", busy0); end
    #2 reset = 1'b0;
    #1;
    tests++; if (out0 !== 1'b0)  begin failed++; $display("FAIL midrst_out got=%b exp=0", out0); end
    tests++; if (busy0 !== 1'b0) begin failed++; $display("FAIL midrst_busy got=%b exp=0", busy0); end
    tests++; if (done0 !== 1'b0) begin failed++; $display("FAIL midrst_done got=%b exp=0", done0); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_press;
    logic [0:16] exp_out;
    logic eo, eb, ed;
    exp_out = 17'b01010111111111111;
    issue0(1'b1, 3, 10);
    // Latched command must ignore later input changes.
    target_level = 1'b0; bounce_edges = '0; stable_cycles = '0;
    for (int k = 0; k <= 17; k++) begin
      eo = (k <= 16) ? exp_out[k] : 1'b1;
      eb = (k <= 15);
      ed = (k == 16);
      tests++; if (out0 !== eo)  begin failed++; $display("FAIL press_out k=%0d got=%b exp=%b", k, out0, eo); end
      tests++; if (busy0 !== eb) begin failed++; $display("FAIL press_busy k=%0d got=%b exp=%b", k, busy0, eb); end
      tests++; if (done0 !== ed) begin failed++; $display("FAIL press_done k=%0d got=%b exp=%b", k, done0, ed); end
      if (k < 17) @(negedge clk);
    end
  endtask

  task automatic test_release;
    logic [0:14] exp_out;
    logic eo, eb, ed;
    exp_out = 15'b101000000000000;
    issue0(1'b0, 2, 10);
    for (int k = 0; k <= 15; k++) begin
      eo = (k <= 14) ? exp_out[k] : 1'b0;
      eb = (k <= 13);
      ed = (k == 14);
      tests++; if (out0 !== eo)  begin failed++; $display("FAIL rel_out k=%0d got=%b exp=%b", k, out0, eo); end
      tests++; if (busy0 !== eb) begin failed++; $display("FAIL rel_busy k=%0d got=%b exp=%b", k, busy0, eb); end
      tests++; if (done0 !== ed) begin failed++; $display("FAIL rel_done k=%0d got=%b exp=%b", k, done0, ed); end
      if (k < 15) @(negedge clk);
    end
  endtask

  task automatic test_zero_edges;
    issue0(1'b1, 0, 0);
    tests++; if (out0 !== 1'b1)  begin failed++; $display("FAIL e0_out0 got=%b exp=1", out0); end
    tests++; if (busy0 !== 1'b1) begin failed++; $display("FAIL e0_busy0 got=%b exp=1", busy0); end
    tests++; if (done0 !== 1'b0) begin failed++; $display("FAIL e0_done0 got=%b exp=0", done0); end
    // Stray start (different target) while busy must be ignored.
    target_level = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    tests++; if (done0 !== 1'b1) begin failed++; $display("FAIL e0_done1 got=%b exp=1", done0); end
    tests++; if (busy0 !== 1'b0) begin failed++; $display("FAIL e0_busy1 got=%b exp=0", busy0); end
    tests++; if (out0 !== 1'b1)  begin failed++; $display("FAIL e0_out1 got=%b exp=1", out0); end
    for (int k = 2; k < 8; k++) begin
      @(negedge clk);
      tests++; if (done0 !== 1'b0) begin failed++; $display("FAIL e0_extra_done k=%0d got=%b exp=0", k, done0); end
      tests++; if (busy0 !== 1'b0) begin failed++; $display("FAIL e0_extra_busy k=%0d got=%b exp=0", k, busy0); end
      tests++; if (out0 !== 1'b1)  begin failed++; $display("FAIL e0_hold k=%0d got=%b exp=1", k, out0); end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    target_level = 1'b1; bounce_edges = 4'd1; stable_cycles = 24'd2;
    start0 = 1'b1;
    @(negedge clk);  // k0
    tests++; if (out0 !== 1'b0)  begin failed++; $display("FAIL b2b_out_k0 got=%b exp=0", out0); end
    tests++; if (busy0 !== 1'b1) begin failed++; $display("FAIL b2b_busy_k0 got=%b exp=1", busy0); end
    repeat (4) @(negedge clk);  // k4
    tests++; if (done0 !== 1'b1) begin failed++; $display("FAIL b2b_done_k4 got=%b exp=1", done0); end
    tests++; if (out0 !== 1'b1)  begin failed++; $display("FAIL b2b_out_k4 got=%b exp=1", out0); end
    @(negedge clk);  // k5: idle gap
    tests++; if (busy0 !== 1'b0) begin failed++; $display("FAIL b2b_gap_busy got=%b exp=0", busy0); end
    tests++; if (done0 !== 1'b0) begin failed++; $display("FAIL b2b_gap_done got=%b exp=0", done0); end
    @(negedge clk);  // k6: second command accepted
    start0 = 1'b0;
    tests++; if (busy0 !== 1'b1) begin failed++; $display("FAIL b2b_busy_k6 got=%b exp=1", busy0); end
    tests++; if (out0 !== 1'b0)  begin failed++; $display("FAIL b2b_out_k6 got=%b exp=0", out0); end
    wait_done0(20, n);
    tests++; if (n !== 4) begin failed++; $display("FAIL b2b_second_done_delay got=%0d exp=4", n); end
  endtask

  task automatic test_random;
    logic [15:0] cur;
    int d[8];
    int t_exp[9];
    int ntr, last_t, done_k, gap;
    logic prev;
    cur = m_lfsr;
    t_exp[0] = 0;
    for (int p = 0; p < 8; p++) begin
      d[p] = int'(cur[2:0]) + 1;
      t_exp[p+1] = t_exp[p] + d[p];
      for (int i = 0; i < d[p]; i++) cur = ref_step(cur);
    end
    prev = out1;
    tests++; if (prev !== 1'b0) begin failed++; $display("FAIL rnd_idle_out got=%b exp=0", prev); end
    target_level = 1'b0; bounce_edges = 4'd4; stable_cycles = 24'd20;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    ntr = 0; last_t = 0; done_k = -1;
    for (int k = 0; k < 130 && done_k < 0; k++) begin
      if (out1 !== prev) begin
        if (ntr < 8) begin
          tests++;
          if (k != t_exp[ntr]) begin failed++; $display("FAIL rnd_edge%0d_time got=%0d exp=%0d", ntr, k, t_exp[ntr]); end
        end
        if (ntr > 0) begin
          gap = k - last_t;
          tests++;
          if (gap < 1 || gap > 8) begin failed++; $display("FAIL rnd_dwell%0d got=%0d exp=1..8", ntr, gap); end
        end
        last_t = k; ntr++; prev = out1;
      end
      if (done1 === 1'b1) done_k = k;
      else @(negedge clk);
    end
    tests++; if (ntr != 8) begin failed++; $display("FAIL rnd_transitions got=%0d exp=8", ntr); end
    tests++; if (done_k != t_exp[8] + 20) begin failed++; $display("FAIL rnd_duration got=%0d exp=%0d", done_k, t_exp[8] + 20); end
    tests++; if (out1 !== 1'b0) begin failed++; $display("FAIL rnd_final_out got=%b exp=0", out1); end
  endtask

  task automatic test_closed_loop;
    int n, c0, c1;
    issue0(1'b0, 0, 0);
    wait_done0(10, n);
    repeat (12) @(negedge clk);
    tests++; if (deb !== 1'b0) begin failed++; $display("FAIL loop_pre_deb got=%b exp=0", deb); end
    c0 = press_count;
    issue0(1'b1, 3, 10);
    wait_done0(40, n);
    tests++; if (n >= 40) begin failed++; $display("FAIL loop_press_timeout got=%0d exp<40", n); end
    @(negedge clk);
    issue0(1'b0, 2, 10);
    wait_done0(40, n);
    tests++; if (n >= 40) begin failed++; $display("FAIL loop_release_timeout got=%0d exp<40", n); end
    repeat (12) @(negedge clk);
    tests++; if (press_count !== c0 + 1) begin failed++; $display("FAIL loop_count_full got=%0d exp=%0d", press_count, c0 + 1); end
    tests++; if (deb !== 1'b0) begin failed++; $display("FAIL loop_deb_released got=%b exp=0", deb); end
    c1 = press_count;
    issue0(1'b1, 4, 4);
    wait_done0(40, n);
    tests++; if (n >= 40) begin failed++; $display("FAIL loop_short_timeout got=%0d exp<40", n); end
    // Immediate release: held high only 7 cycles, below the debounce window.
    target_level = 1'b0; bounce_edges = '0; stable_cycles = '0; start0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start0 = 1'b0;
    tests++; if (out0 !== 1'b0) begin failed++; $display("FAIL loop_short_rel_out got=%b exp=0", out0); end
    repeat (12) @(negedge clk);
    tests++; if (press_count !== c1) begin failed++; $display("FAIL loop_count_short got=%0d exp=%0d", press_count, c1); end
    tests++; if (deb !== 1'b0) begin failed++; $display("FAIL loop_deb_short got=%b exp=0", deb); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    test_reset();
    test_press();
    test_release();
    test_zero_edges();
    test_back_to_back();
    test_random();
    test_closed_loop();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
